// File: rtl/controller_sequencer_pkg.sv
// rtl/controller_sequencer_pkg.sv - opcodes, T-state constants and control-word decode for the SAP sequencer
package controller_sequencer_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Every field is active-high here; polarity flips happen at the pins.
    typedef struct packed {
        logic cp;
        logic ep;
        logic mar_in;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] t_state, input logic [3:0] opcode);
        ctrl_t c;
        c = '0;
        unique case (t_state)
            T1: begin c.ep = 1'b1; c.mar_in = 1'b1; end
            T2: c.cp = 1'b1;
            T3: begin c.ce = 1'b1; c.li = 1'b1; end
            T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    c.ei = 1'b1; c.mar_in = 1'b1;
                end else if (opcode == OP_OUT) begin
                    c.ea = 1'b1; c.lo = 1'b1;
                end
            end
            T5: begin
                if (opcode == OP_LDA) begin
                    c.ce = 1'b1; c.la = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    c.ce = 1'b1; c.lb = 1'b1;
                end
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    c.eu = 1'b1; c.la = 1'b1;
                    c.su = (opcode == OP_SUB);
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - opcode/mode inputs and control-word outputs of the sequencer
interface controller_sequencer_if;
    logic [3:0] OPCODE;
    logic       _PROG;
    logic       CP;
    logic       EP;
    logic       _EN_MAR_IN;
    logic       _CE;
    logic       _LI;
    logic       _EI;
    logic       _LA;
    logic       EA;
    logic       SU;
    logic       EU;
    logic       _LB;
    logic       _LO;
    logic       HALT;
    logic [5:0] T_STATE;

    modport master (
        input  OPCODE, _PROG,
        output CP, EP, _EN_MAR_IN, _CE, _LI, _EI, _LA, EA, SU, EU, _LB, _LO, HALT, T_STATE
    );

    modport slave (
        output OPCODE, _PROG,
        input  CP, EP, _EN_MAR_IN, _CE, _LI, _EI, _LA, EA, SU, EU, _LB, _LO, HALT, T_STATE
    );
endinterface

// File: rtl/controller_sequencer_ring_counter_6.sv
// rtl/controller_sequencer_ring_counter_6.sv - one-hot 6-state ring with hold and synchronous load-T1
module ring_counter_6
    import controller_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       load_t1,
    output logic [5:0] state
);
    logic [5:0] state_d, state_q;

    // load_t1 wins over hold so programming mode always parks the ring at T1.
    always_comb begin
        state_d = state_q;
        if (load_t1)
            state_d = T1;
        else if (!hold)
            state_d = {state_q[4:0], state_q[5]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= T1;
        else
            state_q <= state_d;
    end

    assign state = state_q;
endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP instruction-cycle controller: ring counter plus opcode decode
module controller_sequencer
    import controller_sequencer_pkg::*;
(
    input  logic                      CLOCK,
    input  logic                      RESET,
    controller_sequencer_if.master    bus
);
    logic [5:0] t_state;
    logic       halt_d, halt_q;
    logic       running;
    logic       hlt_at_t4;
    ctrl_t      ctrl;

    assign running   = !RESET && bus._PROG && !halt_q;
    assign hlt_at_t4 = running && (t_state == T4) && (bus.OPCODE == OP_HLT);

    ring_counter_6 u_ring (
        .clk     (CLOCK),
        .rst     (RESET),
        .hold    (!running || hlt_at_t4),
        .load_t1 (!bus._PROG),
        .state   (t_state)
    );

    always_comb begin
        halt_d = halt_q;
        if (hlt_at_t4)
            halt_d = 1'b1;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end

    // Gating by running makes RESET, programming mode and halt silence the datapath combinationally.
    always_comb begin
        ctrl = '0;
        if (running)
            ctrl = decode(t_state, bus.OPCODE);
    end

    assign bus.CP         = ctrl.cp;
    assign bus.EP         = ctrl.ep;
    assign bus._EN_MAR_IN = !ctrl.mar_in;
    assign bus._CE        = !ctrl.ce;
    assign bus._LI        = !ctrl.li;
    assign bus._EI        = !ctrl.ei;
    assign bus._LA        = !ctrl.la;
    assign bus.EA         = ctrl.ea;
    assign bus.SU         = ctrl.su;
    assign bus.EU         = ctrl.eu;
    assign bus._LB        = !ctrl.lb;
    assign bus._LO        = !ctrl.lo;
    assign bus.HALT       = halt_q;
    assign bus.T_STATE    = t_state;
endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - directed self-checking bench for controller_sequencer
module tb_controller_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    controller_sequencer_if bus ();

    controller_sequencer dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pin vector {CP,EP,_EN_MAR_IN,_CE,_LI,_EI,_LA,EA,SU,EU,_LB,_LO,HALT}; masks flip a pin to its active level.
    localparam logic [12:0] IDLE   = 13'b0011111000110;
    localparam logic [12:0] M_CP   = 13'h1000;
    localparam logic [12:0] M_EP   = 13'h0800;
    localparam logic [12:0] M_MAR  = 13'h0400;
    localparam logic [12:0] M_CE   = 13'h0200;
    localparam logic [12:0] M_LI   = 13'h0100;
    localparam logic [12:0] M_EI   = 13'h0080;
    localparam logic [12:0] M_LA   = 13'h0040;
    localparam logic [12:0] M_EA   = 13'h0020;
    localparam logic [12:0] M_SU   = 13'h0010;
    localparam logic [12:0] M_EU   = 13'h0008;
    localparam logic [12:0] M_LB   = 13'h0004;
    localparam logic [12:0] M_LO   = 13'h0002;
    localparam logic [12:0] M_HALT = 13'h0001;

    logic [12:0] obs;
    assign obs = {bus.CP, bus.EP, bus._EN_MAR_IN, bus._CE, bus._LI, bus._EI, bus._LA,
                  bus.EA, bus.SU, bus.EU, bus._LB, bus._LO, bus.HALT};

    always @(negedge clk) begin
        if (!rst) begin
            int drivers;
            drivers = int'(bus.EP) + int'(!bus._CE) + int'(!bus._EI) + int'(bus.EA) + int'(bus.EU);
            total++;
            if (!$onehot(bus.T_STATE)) begin
                bad++;
                $display("FAIL onehot t_state=%b", bus.T_STATE);
            end
            total++;
            if (drivers > 1) begin
                bad++;
                $display("FAIL bus_drivers got=%0d need<=1 t_state=%b", drivers, bus.T_STATE);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; bus._PROG = 1'b1; bus.OPCODE = 4'b0000;
        #1;
        total++;
        if (bus.T_STATE !== 6'b000001 || obs !== IDLE) begin
            bad++;
            $display("FAIL reset_init t=%b ctl=%b need t=000001 ctl=%b", bus.T_STATE, obs, IDLE);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if (bus.T_STATE !== 6'b000100) begin
            bad++;
            $display("FAIL reach_t3 t=%b need 000100", bus.T_STATE);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.T_STATE !== 6'b000001 || obs !== IDLE) begin
            bad++;
            $display("FAIL reset_async t=%b ctl=%b need t=000001 ctl=%b", bus.T_STATE, obs, IDLE);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        total++;
        if (bus.T_STATE !== 6'b000001 || obs !== (IDLE ^ M_EP ^ M_MAR)) begin
            bad++;
            $display("FAIL reset_release t=%b ctl=%b need t=000001 ctl=%b", bus.T_STATE, obs, IDLE ^ M_EP ^ M_MAR);
        end
    endtask

    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6);
        logic [12:0] exp_ctl [6];
        exp_ctl[0] = IDLE ^ M_EP ^ M_MAR;
        exp_ctl[1] = IDLE ^ M_CP;
        exp_ctl[2] = IDLE ^ M_CE ^ M_LI;
        exp_ctl[3] = e4;
        exp_ctl[4] = e5;
        exp_ctl[5] = e6;
        bus.OPCODE = op;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.T_STATE !== (6'b000001 << i) || obs !== exp_ctl[i]) begin
                bad++;
                $display("FAIL %s_T%0d t=%b ctl=%b need t=%b ctl=%b", name, i + 1,
                         bus.T_STATE, obs, 6'b000001 << i, exp_ctl[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lda();
        run_instr("lda", 4'b0000, IDLE ^ M_EI ^ M_MAR, IDLE ^ M_CE ^ M_LA, IDLE);
    endtask

    task automatic test_add_sub();
        run_instr("sub", 4'b0010, IDLE ^ M_EI ^ M_MAR, IDLE ^ M_CE ^ M_LB, IDLE ^ M_SU ^ M_EU ^ M_LA);
        run_instr("add", 4'b0001, IDLE ^ M_EI ^ M_MAR, IDLE ^ M_CE ^ M_LB, IDLE ^ M_EU ^ M_LA);
    endtask

    task automatic test_out_nop();
        run_instr("out", 4'b1110, IDLE ^ M_EA ^ M_LO, IDLE, IDLE);
        run_instr("nop", 4'b0101, IDLE, IDLE, IDLE);
    endtask

    task automatic test_prog();
        bus.OPCODE = 4'b0000;
        repeat (4) @(negedge clk);
        bus._PROG = 1'b0;
        #1;
        total++;
        if (bus.T_STATE !== 6'b010000 || obs !== IDLE) begin
            bad++;
            $display("FAIL prog_enter t=%b ctl=%b need t=010000 ctl=%b", bus.T_STATE, obs, IDLE);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus.T_STATE !== 6'b000001 || obs !== IDLE) begin
                bad++;
                $display("FAIL prog_hold%0d t=%b ctl=%b need t=000001 ctl=%b", i, bus.T_STATE, obs, IDLE);
            end
        end
        bus._PROG = 1'b1;
        #1;
        total++;
        if (bus.T_STATE !== 6'b000001 || obs !== (IDLE ^ M_EP ^ M_MAR)) begin
            bad++;
            $display("FAIL prog_release t=%b ctl=%b need t=000001 ctl=%b", bus.T_STATE, obs, IDLE ^ M_EP ^ M_MAR);
        end
        @(negedge clk);
        total++;
        if (bus.T_STATE !== 6'b000010 || obs !== (IDLE ^ M_CP)) begin
            bad++;
            $display("FAIL prog_t2 t=%b ctl=%b need t=000010 ctl=%b", bus.T_STATE, obs, IDLE ^ M_CP);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_halt();
        bus.OPCODE = 4'b1111;
        repeat (3) @(negedge clk);
        total++;
        if (bus.T_STATE !== 6'b001000 || obs !== IDLE) begin
            bad++;
            $display("FAIL hlt_t4 t=%b ctl=%b need t=001000 ctl=%b", bus.T_STATE, obs, IDLE);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.T_STATE !== 6'b001000 || obs !== (IDLE ^ M_HALT)) begin
                bad++;
                $display("FAIL halted%0d t=%b ctl=%b need t=001000 ctl=%b", i, bus.T_STATE, obs, IDLE ^ M_HALT);
            end
        end
        bus._PROG = 1'b0;
        @(negedge clk);
        bus._PROG = 1'b1;
        @(negedge clk);
        total++;
        if (bus.HALT !== 1'b1) begin
            bad++;
            $display("FAIL halt_sticky_prog got=%b need=1", bus.HALT);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.T_STATE !== 6'b000001 || obs !== IDLE) begin
            bad++;
            $display("FAIL halt_reset t=%b ctl=%b need t=000001 ctl=%b", bus.T_STATE, obs, IDLE);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_out_nop();
        test_prog();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
